// File: rtl/packet_router_n.sv
// -----------------------------------------------------------------------------
// packet_router_n
// Routes packets from one AXI-Stream ingress to NUM_PORTS egress streams. The
// destination is the field tdata[SEL_LSB +: PSEL_W] of each packet's first
// beat; body beats follow their head. Each egress has a first-word-fall-through
// FIFO of DEPTH beats. A read-only AXI-Lite bank exposes packet counters.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   s_axil_ar*/r*        : AXI-Lite read channel (address bits [7:2] decoded)
//   s_axis_*             : ingress stream (tdata, tlast, tvalid, tready)
//   m_axis_*             : egress streams, port i at tdata slice i*TDATA_WIDTH
// Register map (word index): 0 rx_pkts, 1..NUM_PORTS tx_pkts[idx-1],
//   NUM_PORTS+1 config {8'h01, NUM_PORTS, DEPTH}, else 0 with SLVERR.
// -----------------------------------------------------------------------------
module packet_router_n #(
   parameter int NUM_PORTS   = 4,
   parameter int TDATA_WIDTH = 32,
   parameter int DEPTH       = 32,
   parameter int SEL_LSB     = 0
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [31:0]                      s_axil_araddr,
   input  logic                             s_axil_arvalid,
   output logic                             s_axil_arready,
   output logic [31:0]                      s_axil_rdata,
   output logic [1:0]                       s_axil_rresp,
   output logic                             s_axil_rvalid,
   input  logic                             s_axil_rready,
   input  logic [TDATA_WIDTH-1:0]           s_axis_tdata,
   input  logic                             s_axis_tlast,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   output logic [NUM_PORTS*TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [NUM_PORTS-1:0]             m_axis_tlast,
   output logic [NUM_PORTS-1:0]             m_axis_tvalid,
   input  logic [NUM_PORTS-1:0]             m_axis_tready
);

   localparam int PSEL_W = $clog2(NUM_PORTS);
   localparam int AW     = $clog2(DEPTH);
   localparam int PW     = AW + 1;

   typedef enum logic {
      ST_HEAD = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   // ingress FSM
   state_t              state_q, state_d;
   logic [PSEL_W-1:0]   dest_q, dest_d;
   logic [PSEL_W-1:0]   head_sel;
   logic [PSEL_W-1:0]   cur_dest;
   logic                in_ready;
   logic                in_accept;

   // FIFOs
   logic [TDATA_WIDTH:0]                fifo_mem_q [NUM_PORTS][DEPTH];
   logic [NUM_PORTS-1:0][PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [NUM_PORTS-1:0][PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [NUM_PORTS-1:0]                empty, full, push, pop;

   // counters
   logic [31:0]                         rx_pkts_q, rx_pkts_d;
   logic [NUM_PORTS-1:0][31:0]          tx_pkts_q, tx_pkts_d;

   // AXI-Lite read path
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        ar_ready;
   logic        ar_hs;
   logic [5:0]  word;
   logic [5:0]  word_m1;
   logic [31:0] rd_val;
   logic [1:0]  rd_resp;
   logic        unused_bits;

   // Ingress steering: head beats route on their own select field, body beats
   // follow the latched destination. tready is held low while in reset.
   always_comb begin
      state_d  = state_q;
      dest_d   = dest_q;
      head_sel = s_axis_tdata[SEL_LSB +: PSEL_W];
      if (state_q == ST_HEAD) begin
         cur_dest = head_sel;
      end else begin
         cur_dest = dest_q;
      end
      in_ready  = resetn & ~full[cur_dest];
      in_accept = s_axis_tvalid & in_ready;
      case (state_q)
         ST_HEAD: begin
            if (in_accept && !s_axis_tlast) begin
               state_d = ST_BODY;
               dest_d  = head_sel;
            end else begin
               state_d = ST_HEAD;
            end
         end
         ST_BODY: begin
            if (in_accept && s_axis_tlast) begin
               state_d = ST_HEAD;
            end else begin
               state_d = ST_BODY;
            end
         end
         default: begin
            state_d = ST_HEAD;
         end
      endcase
   end

   // FIFO flags and pointer updates. Full is judged on the registered
   // occupancy only, so a pop in the same cycle does not admit a push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      empty    = '0;
      full     = '0;
      push     = '0;
      pop      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                    (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         push[i] = in_accept && (cur_dest == PSEL_W'(i));
         pop[i]  = ~empty[i] & m_axis_tready[i];
         if (push[i]) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
         end else begin
            wr_ptr_d[i] = wr_ptr_q[i];
         end
         if (pop[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
         end else begin
            rd_ptr_d[i] = rd_ptr_q[i];
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            fifo_mem_q[i][wr_ptr_q[i][AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
         end
      end
   end

   // First-word-fall-through egress: the head entry is always presented.
   always_comb begin
      m_axis_tdata = '0;
      m_axis_tlast = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         m_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] =
            fifo_mem_q[i][rd_ptr_q[i][AW-1:0]][TDATA_WIDTH-1:0];
         m_axis_tlast[i] = fifo_mem_q[i][rd_ptr_q[i][AW-1:0]][TDATA_WIDTH];
      end
      m_axis_tvalid = ~empty;
   end

   // Packet counters, free-running with natural 32-bit wrap.
   always_comb begin
      if (in_accept && s_axis_tlast) begin
         rx_pkts_d = rx_pkts_q + 32'd1;
      end else begin
         rx_pkts_d = rx_pkts_q;
      end
      tx_pkts_d = tx_pkts_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pop[i] && m_axis_tlast[i]) begin
            tx_pkts_d[i] = tx_pkts_q[i] + 32'd1;
         end else begin
            tx_pkts_d[i] = tx_pkts_q[i];
         end
      end
   end

   // AXI-Lite register decode and read-response holding.
   always_comb begin
      ar_ready = resetn & ~rvalid_q;
      ar_hs    = s_axil_arvalid & ar_ready;
      word     = s_axil_araddr[7:2];
      word_m1  = word - 6'd1;
      rd_val   = 32'd0;
      rd_resp  = 2'b10;
      if (word == 6'd0) begin
         rd_val  = rx_pkts_q;
         rd_resp = 2'b00;
      end else if (word <= 6'(NUM_PORTS)) begin
         rd_val  = tx_pkts_q[word_m1[PSEL_W-1:0]];
         rd_resp = 2'b00;
      end else if (word == 6'(NUM_PORTS + 1)) begin
         rd_val  = {8'h01, 8'(NUM_PORTS), 16'(DEPTH)};
         rd_resp = 2'b00;
      end else begin
         rd_val  = 32'd0;
         rd_resp = 2'b10;
      end
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_val;
         rresp_d  = rd_resp;
      end else if (rvalid_q && s_axil_rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   assign unused_bits = ^{s_axil_araddr[31:8], s_axil_araddr[1:0], word_m1};

   // State, pointer, counter and read-channel registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_HEAD;
         dest_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rx_pkts_q <= 32'd0;
         tx_pkts_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= 2'b00;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         rx_pkts_q <= rx_pkts_d;
         tx_pkts_q <= tx_pkts_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s_axis_tready  = in_ready;
   assign s_axil_arready = ar_ready;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rdata   = rdata_q;
   assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_packet_router_n.sv
// -----------------------------------------------------------------------------
// tb_packet_router_n
// Scoreboard bench for packet_router_n (NUM_PORTS=4, DEPTH=32). Accepted
// ingress beats are queued with the port their packet was sent to; every
// egress handshake pops the oldest entry for that port and compares.
// -----------------------------------------------------------------------------
module tb_packet_router_n;

   localparam int NP    = 4;
   localparam int W     = 32;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              resetn;
   logic [31:0]       s_axil_araddr;
   logic              s_axil_arvalid;
   logic              s_axil_arready;
   logic [31:0]       s_axil_rdata;
   logic [1:0]        s_axil_rresp;
   logic              s_axil_rvalid;
   logic              s_axil_rready;
   logic [W-1:0]      s_axis_tdata;
   logic              s_axis_tlast;
   logic              s_axis_tvalid;
   logic              s_axis_tready;
   logic [NP*W-1:0]   m_axis_tdata;
   logic [NP-1:0]     m_axis_tlast;
   logic [NP-1:0]     m_axis_tvalid;
   logic [NP-1:0]     m_axis_tready;

   always #5 clk = ~clk;

   packet_router_n #(.NUM_PORTS(NP), .TDATA_WIDTH(W), .DEPTH(DEPTH), .SEL_LSB(0)) dut (
      .clk(clk), .resetn(resetn),
      .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
      .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata),
      .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   typedef struct packed {
      logic [1:0]   dest;
      logic         last;
      logic [W-1:0] data;
   } beat_t;

   beat_t       in_q[$];
   beat_t       sb_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          rdy_pct[NP];
   int          acc_cnt[NP];
   logic [31:0] rx_model;
   logic [31:0] tx_model[NP];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, evaluate handshakes 1 time unit
   // later, then wait for the next falling edge (the rising edge commits them).
   task automatic step();
      int idx;
      if (in_q.size() > 0) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = in_q[0].data;
         s_axis_tlast  = in_q[0].last;
      end else begin
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
      end
      for (int i = 0; i < NP; i++) begin
         m_axis_tready[i] = ($urandom_range(99) < rdy_pct[i]);
      end
      #1;
      for (int i = 0; i < NP; i++) begin
         if (m_axis_tvalid[i] && m_axis_tready[i]) begin
            idx = -1;
            for (int k = 0; k < sb_q.size(); k++) begin
               if (idx < 0 && sb_q[k].dest == 2'(i)) idx = k;
            end
            if (idx < 0) begin
               check_eq($sformatf("unexpected_beat_p%0d", i), 64'd1, 64'd0);
            end else begin
               check_eq($sformatf("egress_p%0d", i), {m_axis_tlast[i], m_axis_tdata[i*W +: W]},
                        {sb_q[idx].last, sb_q[idx].data});
               if (sb_q[idx].last) tx_model[i]++;
               sb_q.delete(idx);
            end
         end
      end
      if (s_axis_tvalid && s_axis_tready) begin
         sb_q.push_back(in_q[0]);
         acc_cnt[in_q[0].dest]++;
         if (in_q[0].last) rx_model++;
         void'(in_q.pop_front());
      end
      @(negedge clk);
   endtask

   // Queue a packet; body_sel >= 0 forces the body beats' select bits.
   task automatic send_pkt(input int dest, input int n, input int body_sel);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.dest = 2'(dest);
         b.last = (k == n - 1);
         b.data = $urandom();
         if (k == 0) b.data[1:0] = 2'(dest);
         else if (body_sel >= 0) b.data[1:0] = 2'(body_sel);
         in_q.push_back(b);
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((in_q.size() > 0 || sb_q.size() > 0) && t < 3000) begin
         step();
         t++;
      end
      if (t >= 3000) check_eq("drain_timeout", 64'd1, 64'd0);
      repeat (3) step();
   endtask

   task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int t = 0;
      s_axil_araddr  = addr;
      s_axil_arvalid = 1'b1;
      s_axil_rready  = 1'b0;
      #1;
      while (!s_axil_arready && t < 10) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 10) check_eq("arready_timeout", 64'd1, 64'd0);
      @(negedge clk);
      s_axil_arvalid = 1'b0;
      #1;
      t = 0;
      while (!s_axil_rvalid && t < 10) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 10) check_eq("rvalid_timeout", 64'd1, 64'd0);
      data = s_axil_rdata;
      resp = s_axil_rresp;
      s_axil_rready = 1'b1;
      @(negedge clk);
      s_axil_rready = 1'b0;
   endtask

   task automatic clear_model();
      in_q.delete();
      sb_q.delete();
      rx_model = 32'd0;
      for (int i = 0; i < NP; i++) begin
         tx_model[i] = 32'd0;
         acc_cnt[i]  = 0;
         rdy_pct[i]  = 100;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [31:0] tx_sum;
      int          acc_before;

      resetn = 1'b0;
      s_axil_araddr = 32'd0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
      s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
      m_axis_tready = '1;
      clear_model();
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_s_tready", s_axis_tready, 0);
      check_eq("rst_m_tvalid", m_axis_tvalid, 0);
      check_eq("rst_arready", s_axil_arready, 0);
      check_eq("rst_rvalid", s_axil_rvalid, 0);
      check_eq("rst_rdata", s_axil_rdata, 0);
      check_eq("rst_rresp", s_axil_rresp, 0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_eq("rel_s_tready", s_axis_tready, 1);
      check_eq("rel_arready", s_axil_arready, 1);
      @(negedge clk);

      // basic routing: one 10-beat packet per port
      for (int p = 0; p < NP; p++) send_pkt(p, 10, -1);
      drain();
      for (int p = 0; p < NP; p++) begin
         axil_read(32'(4 * (p + 1)), rd, rr);
         check_eq($sformatf("tx_pkts_%0d", p), rd, 1);
         check_eq($sformatf("tx_resp_%0d", p), rr, 0);
      end
      axil_read(32'h0, rd, rr);
      check_eq("rx_pkts_basic", rd, 4);
      check_eq("rx_resp_basic", rr, 0);

      // body beats carry port-1 select bits but must stay on port 2
      send_pkt(2, 5, 1);
      drain();

      // one-cycle ingress-to-egress latency
      rdy_pct[0] = 0;
      send_pkt(0, 1, -1);
      step();
      check_eq("latency_tvalid0", m_axis_tvalid[0], 1);
      rdy_pct[0] = 100;
      drain();

      // backpressure: 40-beat packet into a blocked port 3
      rdy_pct[3] = 0;
      acc_before = acc_cnt[3];
      send_pkt(3, 40, -1);
      repeat (45) step();
      check_eq("full_accepted", 64'(acc_cnt[3] - acc_before), DEPTH);
      check_eq("full_s_tready", s_axis_tready, 0);
      check_eq("full_tvalid3", m_axis_tvalid[3], 1);
      rdy_pct[3] = 100;
      drain();
      check_eq("full_total", 64'(acc_cnt[3] - acc_before), 40);

      // single-beat packets, alternating ports, random egress backpressure
      rdy_pct[0] = 75;
      rdy_pct[1] = 75;
      for (int k = 0; k < 20; k++) send_pkt(k % 2, 1, -1);
      drain();
      rdy_pct[0] = 100;
      rdy_pct[1] = 100;
      tx_sum = 32'd0;
      for (int p = 0; p < NP; p++) begin
         axil_read(32'(4 * (p + 1)), rd, rr);
         check_eq($sformatf("tx_model_%0d", p), rd, tx_model[p]);
         tx_sum = tx_sum + rd;
      end
      axil_read(32'h0, rd, rr);
      check_eq("rx_model", rd, rx_model);
      check_eq("rx_eq_sum_tx", rd, tx_sum);
      check_eq("rx_expected", rd, 27);

      // unmapped and config reads
      axil_read(32'h40, rd, rr);
      check_eq("unmapped_data", rd, 0);
      check_eq("unmapped_resp", rr, 2);
      axil_read(32'h18, rd, rr);
      check_eq("unmapped18_resp", rr, 2);
      axil_read(32'h14, rd, rr);
      check_eq("config_data", rd, 32'h0104_0020);
      check_eq("config_resp", rr, 0);

      // reset mid-packet with three beats parked in port 1
      rdy_pct[1] = 0;
      send_pkt(1, 10, -1);
      repeat (3) step();
      check_eq("pre_rst_tvalid1", m_axis_tvalid[1], 1);
      resetn = 1'b0;
      s_axis_tvalid = 1'b0;
      #1;
      check_eq("mid_rst_s_tready", s_axis_tready, 0);
      check_eq("mid_rst_m_tvalid", m_axis_tvalid, 0);
      check_eq("mid_rst_arready", s_axil_arready, 0);
      check_eq("mid_rst_rvalid", s_axil_rvalid, 0);
      check_eq("mid_rst_rdata", s_axil_rdata, 0);
      clear_model();
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_eq("mid_rel_s_tready", s_axis_tready, 1);
      @(negedge clk);
      axil_read(32'h0, rd, rr);
      check_eq("rst_rx_pkts", rd, 0);
      axil_read(32'h8, rd, rr);
      check_eq("rst_tx_pkts1", rd, 0);
      // first beat after reset is a head beat
      send_pkt(2, 3, 1);
      drain();
      axil_read(32'hC, rd, rr);
      check_eq("post_rst_tx2", rd, 1);

      // counter wrap
      force dut.rx_pkts_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.rx_pkts_q;
      @(negedge clk);
      send_pkt(0, 1, -1);
      drain();
      axil_read(32'h0, rd, rr);
      check_eq("rx_wrap", rd, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/packet_router_n.md
# packet_router_n

N-output AXI-Stream packet router: the successor to the two-way even/odd router, generalised to `NUM_PORTS` outputs. The destination is chosen by a configurable bit field of each packet's first beat. Each output has its own FIFO, and an AXI-Lite read-only register bank exposes per-port packet statistics. The block sits between a single ingress stream and `NUM_PORTS` egress consumers.

## Interface
- `NUM_PORTS`, 4: number of outputs; power of 2, range 2..8. `PSEL_W = $clog2(NUM_PORTS)`.
- `TDATA_WIDTH`, 32: stream data width; must be ≥ `SEL_LSB + PSEL_W`.
- `DEPTH`, 32: per-output FIFO depth in beats; power of 2, at least 2.
- `SEL_LSB`, 0: LSB of the destination field `tdata[SEL_LSB +: PSEL_W]` in the first beat.
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: reset; asynchronous assert, active-low.
- `s_axil_araddr` in 32: read address; only bits [7:2] are decoded.
- `s_axil_arvalid` in 1 / `s_axil_arready` out 1: read-address handshake.
- `s_axil_rdata` out 32 / `s_axil_rresp` out 2: read data and response.
- `s_axil_rvalid` out 1 / `s_axil_rready` in 1: read-data handshake.
- `s_axis_tdata` in `TDATA_WIDTH`, `s_axis_tlast` in 1, `s_axis_tvalid` in 1, `s_axis_tready` out 1: ingress stream.
- `m_axis_tdata` out `NUM_PORTS*TDATA_WIDTH`: egress data; port i occupies slice `[i*TDATA_WIDTH +: TDATA_WIDTH]`.
- `m_axis_tlast`, `m_axis_tvalid` out `NUM_PORTS`; `m_axis_tready` in `NUM_PORTS`: egress control, one bit per port.

## Operation
- **Ingress FSM, two states.**
  - `HEAD`: destination `d = s_axis_tdata[SEL_LSB +: PSEL_W]`, computed combinationally. `s_axis_tready = !full[d]`.
    - On an accepted beat with `tlast=0`: latch `dest_q = d` and go to `BODY`.
    - On an accepted beat with `tlast=1` (single-beat packet): stay in `HEAD`.
  - `BODY`: `s_axis_tready = !full[dest_q]`. On an accepted beat with `tlast=1`, go to `HEAD`.
- **Blocking.** Head-of-line blocking is intended: a full destination stalls ingress even if other FIFOs have room. No packet is ever dropped.
- **Egress FIFOs.** Each accepted beat `{tlast, tdata}` is pushed into FIFO[dest]. Each FIFO is first-word-fall-through: `m_axis_tvalid[i] = !empty[i]`, and a pop occurs on `m_axis_tvalid[i] & m_axis_tready[i]`.
- **FIFO flags.** `full` means occupancy equals `DEPTH`; there is no same-cycle bypass of a full FIFO, even if it pops in that cycle. Pointers are `$clog2(DEPTH)+1` bits and wrap naturally.
- **Counters.** All are 32-bit and wrap from 0xFFFF_FFFF to 0.
  - `rx_pkts` increments on every accepted ingress beat with `tlast=1`.
  - `tx_pkts[i]` increments on every egress handshake on port i with `tlast=1`.
- **Register map**, word index = `araddr[7:2]`:
  - 0: `rx_pkts`.
  - 1..`NUM_PORTS`: `tx_pkts[idx-1]`.
  - `NUM_PORTS+1`: config word `{8'h01, 8'(NUM_PORTS), 16'(DEPTH)}`.
  - Any other index: rdata 0, rresp 2'b10 (SLVERR). Mapped reads return rresp 2'b00.
- **AXI-Lite read.** `s_axil_arready = !s_axil_rvalid` (after reset). On an AR handshake, rdata and rresp are registered and `s_axil_rvalid` rises on the next edge. Both hold until `s_axil_rready`.

## Timing
- **Reset values** while `resetn=0`:
  - `s_axis_tready`, all `m_axis_tvalid`, `s_axil_arready`, `s_axil_rvalid`: 0.
  - `s_axil_rdata`: 0; `s_axil_rresp`: 0.
  - All counters and pointers: 0; FSM in `HEAD`.
- **Reset mid-packet.** All FIFO contents and the partial packet are discarded. After release, the next accepted beat is treated as a `HEAD` beat.
- **After release.** `s_axis_tready` and `s_axil_arready` are 1 in the first cycle after reset deasserts, since all FIFOs are empty.
- **Latency.** A beat accepted at edge N is presented with `m_axis_tvalid=1` in the cycle after edge N, i.e. 1 cycle ingress→egress.
- **Throughput.** One beat per cycle into one FIFO, and one beat per cycle out of every port concurrently.
- **Read latency.** An AR handshake at edge N gives rvalid=1 after edge N. The read value is the counter as it was before edge N: a same-edge increment is not visible until a later read.
- **Back-to-back reads.** Reads can be issued every 2 cycles when `rready` is held at 1.
- **Simultaneous push and pop on a non-full FIFO.** Occupancy is unchanged; both operations occur.

## Test plan
- **Basic routing.** With `NUM_PORTS=4`, `SEL_LSB=0`, send one 10-beat packet with first-beat low bits 0, 1, 2, 3 respectively, with all tready=1.
  - Each packet appears intact on ports 0, 1, 2, 3.
  - `tlast` is asserted only on beat 10.
  - `tx_pkts[i]` = 1 for each port.
- **Body beats do not re-route.** Send a 5-beat packet whose first beat selects port 2 and whose body beats carry the select bits for port 1. All 5 beats exit on port 2.
- **Backpressure on a full FIFO.** Hold `m_axis_tready[3]=0` and send a 40-beat packet to port 3 (`DEPTH=32`).
  - `s_axis_tready` drops after 32 beats are accepted.
  - Releasing tready drains all 40 beats in order.
  - No loss or duplication.
- **Single-beat packets.** Send 1-beat packets alternating ports 0 and 1 with random egress backpressure of 25%. Order is preserved per port and `rx_pkts` = sum of `tx_pkts`.
- **Register reads and reset.**
  - Read addresses 0x0, 0x4, 0x14 and 0x40:
    - 0x0 and 0x4 return the expected counts with rresp 0.
    - 0x14 returns `0x0104_0020` for `NUM_PORTS=4`, `DEPTH=32`.
    - 0x40 returns 0 with rresp 2.
  - Assert `resetn=0` mid-packet. All outputs return to their reset values and the counters read 0.
- **Counter wrap.** Force `rx_pkts` to 0xFFFF_FFFF, then send one packet. `rx_pkts` reads 0.
